// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: round-robin shares the register file write port among NUM_REQ
// sources and tracks per-register busy bits for decode-stage hazard checks.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 32,
  parameter int AW      = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*AW-1:0]   req_rd,
  input  logic [NUM_REQ*XLEN-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic                    issue_valid,
  input  logic [AW-1:0]           issue_rd,
  output logic                    issue_stall,
  input  logic [AW-1:0]           rs1,
  input  logic [AW-1:0]           rs2,
  output logic                    rs1_busy,
  output logic                    rs2_busy,
  output logic                    reg_wr_en,
  output logic [AW-1:0]           rd,
  output logic [XLEN-1:0]         rd_data
);

  localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NREG = 1 << AW;
  localparam logic [NREG-1:0] X0_MASK = {{(NREG-1){1'b1}}, 1'b0};

  logic [PW-1:0]   rr_ptr_r;
  logic [PW-1:0]   grant_idx_s;
  logic [PW-1:0]   nxt_ptr_s;
  logic            found_s;
  logic            hit_s;
  int              idx_s;
  logic [AW-1:0]   sel_rd_s;
  logic [XLEN-1:0] sel_data_s;
  logic [NREG-1:0] busy_r;
  logic [NREG-1:0] clr_vec_s;
  logic [NREG-1:0] set_vec_s;
  logic            issue_nz_s;
  logic            clr_same_s;
  logic            set_s;

  // Round-robin search starting at rr_ptr_r; first valid requester wins.
  always_comb begin
    found_s     = 1'b0;
    hit_s       = 1'b0;
    idx_s       = 0;
    grant_idx_s = '0;
    sel_rd_s    = '0;
    sel_data_s  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s       = (int'(rr_ptr_r) + k) % NUM_REQ;
      hit_s       = !found_s && req_valid[idx_s];
      grant_idx_s = hit_s ? PW'(idx_s) : grant_idx_s;
      sel_rd_s    = hit_s ? req_rd[idx_s*AW +: AW] : sel_rd_s;
      sel_data_s  = hit_s ? req_data[idx_s*XLEN +: XLEN] : sel_data_s;
      found_s     = found_s | hit_s;
    end
  end

  assign nxt_ptr_s = (grant_idx_s == PW'(NUM_REQ - 1)) ? '0 : grant_idx_s + PW'(1);
  assign req_ready = (found_s && !rst) ? (NUM_REQ'(1) << grant_idx_s) : '0;

  // Write stage: register the winner onto the regfile port and advance the pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_wr_en <= 1'b0;
      rd        <= '0;
      rd_data   <= '0;
      rr_ptr_r  <= '0;
    end else if (found_s) begin
      reg_wr_en <= (sel_rd_s != '0);
      rd        <= sel_rd_s;
      rd_data   <= sel_data_s;
      rr_ptr_r  <= nxt_ptr_s;
    end else begin
      reg_wr_en <= 1'b0;
    end
  end

  // The stall uses the pre-clear busy bit, yet a reservation landing on the
  // register being freed this edge still takes effect (set beats clear).
  assign issue_nz_s  = (issue_rd != '0);
  assign issue_stall = issue_valid && issue_nz_s && busy_r[issue_rd];
  assign clr_same_s  = reg_wr_en && (rd == issue_rd);
  assign set_s       = issue_valid && issue_nz_s && (!issue_stall || clr_same_s);
  assign clr_vec_s   = reg_wr_en ? (NREG'(1) << rd) : '0;
  assign set_vec_s   = set_s ? (NREG'(1) << issue_rd) : '0;

  assign rs1_busy = (rs1 != '0) && busy_r[rs1];
  assign rs2_busy = (rs2 != '0) && busy_r[rs2];

  // Busy scoreboard update.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= '0;
    end else begin
      busy_r <= ((busy_r & ~clr_vec_s) | set_vec_s) & X0_MASK;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; expected writes go through a queue scoreboard.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic [14:0] req_rd;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_stall;
  logic [4:0]  rs1, rs2;
  logic        rs1_busy, rs2_busy;
  logic        reg_wr_en;
  logic [4:0]  rd;
  logic [31:0] rd_data;

  typedef struct packed {
    logic        en;
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t         q[$];
  logic [4:0]  last_rd;
  logic [31:0] last_data;
  int          checks;
  int          failures;

  regfile_wb_arbiter #(.NUM_REQ(3), .XLEN(32), .AW(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_stall(issue_stall),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .reg_wr_en(reg_wr_en), .rd(rd), .rd_data(rd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [4:0] r, input logic [31:0] d);
    req_rd[i*5 +: 5]    = r;
    req_data[i*32 +: 32] = d;
  endtask

  // Drive valids, check the grant, and queue the write it should produce.
  task automatic apply(input logic [2:0] v, input logic [2:0] exp_ready);
    wr_t e;
    int  g;
    req_valid = v;
    #1;
    chk("req_ready", {61'd0, req_ready}, {61'd0, exp_ready});
    g = -1;
    for (int i = 0; i < 3; i++) begin
      if (exp_ready[i]) g = i;
    end
    if (g >= 0) begin
      e.rd      = req_rd[g*5 +: 5];
      e.data    = req_data[g*32 +: 32];
      e.en      = (e.rd != 5'd0);
      last_rd   = e.rd;
      last_data = e.data;
    end else begin
      e.en   = 1'b0;
      e.rd   = last_rd;
      e.data = last_data;
    end
    q.push_back(e);
  endtask

  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    req_valid = 3'b000;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("reg_wr_en", {63'd0, reg_wr_en}, {63'd0, e.en});
      chk("rd", {59'd0, rd}, {59'd0, e.rd});
      chk("rd_data", {32'd0, rd_data}, {32'd0, e.data});
    end else begin
      chk("sb_underflow", 64'd0, 64'd1);
    end
  endtask

  task automatic peek(input logic [4:0] a, input logic [4:0] b, input logic ea, input logic eb);
    rs1 = a;
    rs2 = b;
    #1;
    chk("rs1_busy", {63'd0, rs1_busy}, {63'd0, ea});
    chk("rs2_busy", {63'd0, rs2_busy}, {63'd0, eb});
  endtask

  initial begin
    checks = 0; failures = 0;
    last_rd = 5'd0; last_data = 32'd0;
    rst = 1'b1;
    req_valid = 3'b111; req_rd = 15'd0; req_data = 96'd0;
    set_req(0, 5'd1, 32'h0000_0001);
    issue_valid = 1'b0; issue_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", {63'd0, reg_wr_en}, 64'd0);
    chk("rst_rd", {59'd0, rd}, 64'd0);
    chk("rst_rd_data", {32'd0, rd_data}, 64'd0);
    chk("rst_ready", {61'd0, req_ready}, 64'd0);
    for (int r = 0; r < 32; r++) begin
      rs1 = 5'(r);
      rs2 = 5'(31 - r);
      #1;
      chk("rst_busy", {62'd0, rs1_busy, rs2_busy}, 64'd0);
    end
    req_valid = 3'b000;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single write from requester 0
    set_req(0, 5'd5, 32'hDEAD_BEEF);
    apply(3'b001, 3'b001);
    tick();
    // Requester 2 alone moves the pointer back to 0
    set_req(2, 5'd3, 32'h0000_0033);
    apply(3'b100, 3'b100);
    tick();

    // Round-robin with all three held valid
    set_req(0, 5'd10, 32'hA0A0_0000);
    set_req(1, 5'd11, 32'hB1B1_1111);
    set_req(2, 5'd12, 32'hC2C2_2222);
    for (int c = 0; c < 6; c++) begin
      apply(3'b111, 3'(3'b001 << (c % 3)));
      tick();
    end

    // Scoreboard: reserve x7, re-issue stalls, write via req1 clears
    issue_valid = 1'b1; issue_rd = 5'd7;
    apply(3'b000, 3'b000);
    chk("stall_first", {63'd0, issue_stall}, 64'd0);
    tick();
    issue_valid = 1'b0;
    peek(5'd7, 5'd7, 1'b1, 1'b1);
    issue_valid = 1'b1;
    apply(3'b000, 3'b000);
    chk("stall_reissue", {63'd0, issue_stall}, 64'd1);
    tick();
    issue_valid = 1'b0;
    peek(5'd7, 5'd0, 1'b1, 1'b0);
    set_req(1, 5'd7, 32'h0000_0777);
    apply(3'b010, 3'b010);
    tick();
    peek(5'd7, 5'd12, 1'b1, 1'b0);
    apply(3'b000, 3'b000);
    tick();
    peek(5'd7, 5'd7, 1'b0, 1'b0);

    // Same-cycle set/clear on x9
    issue_valid = 1'b1; issue_rd = 5'd9;
    apply(3'b000, 3'b000);
    chk("stall_x9_first", {63'd0, issue_stall}, 64'd0);
    tick();
    issue_valid = 1'b0;
    set_req(0, 5'd9, 32'h9999_0009);
    apply(3'b001, 3'b001);
    tick();
    issue_valid = 1'b1; issue_rd = 5'd9;
    apply(3'b000, 3'b000);
    chk("stall_x9_same", {63'd0, issue_stall}, 64'd1);
    tick();
    issue_valid = 1'b0;
    peek(5'd0, 5'd9, 1'b0, 1'b1);

    // Issue x0 never stalls or reserves
    issue_valid = 1'b1; issue_rd = 5'd0;
    apply(3'b000, 3'b000);
    chk("stall_x0", {63'd0, issue_stall}, 64'd0);
    tick();
    issue_valid = 1'b0;
    peek(5'd0, 5'd9, 1'b0, 1'b1);

    // rd=0 request is granted but not written
    set_req(1, 5'd0, 32'h1234_5678);
    apply(3'b010, 3'b010);
    tick();

    // Reset while req2 is granted drops the write and clears busy
    set_req(2, 5'd12, 32'hCAFE_F00D);
    apply(3'b100, 3'b100);
    req_valid = 3'b100;
    rst = 1'b1;
    #1;
    chk("ready_in_rst", {61'd0, req_ready}, 64'd0);
    q.delete();
    @(posedge clk);
    #1;
    chk("mid_rst_wr_en", {63'd0, reg_wr_en}, 64'd0);
    chk("mid_rst_rd", {59'd0, rd}, 64'd0);
    chk("mid_rst_rd_data", {32'd0, rd_data}, 64'd0);
    peek(5'd9, 5'd7, 1'b0, 1'b0);
    req_valid = 3'b000;
    rst = 1'b0;
    last_rd = 5'd0; last_data = 32'd0;
    apply(3'b000, 3'b000);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
